// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage access unit: data sizes, FSM states,
// byte-enable patterns and the store-side lane helpers.
package mem_pkg;

    localparam logic [1:0] DS_BYTE = 2'b00;
    localparam logic [1:0] DS_HALF = 2'b01;
    localparam logic [1:0] DS_WORD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_t;

    // Big-endian lanes: bit 3 covers bits 31:24, the byte at addr[1:0] == 0.
    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b1000;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    function automatic logic is_misaligned(input logic [1:0] ds, input logic [1:0] a);
        logic bad;
        case (ds)
            DS_BYTE: bad = 1'b0;
            DS_HALF: bad = a[0];
            DS_WORD: bad = (a != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] ds, input logic [1:0] a);
        logic [3:0] be;
        case (ds)
            DS_BYTE: be = BE_BYTE0 >> a;
            DS_HALF: be = a[1] ? BE_LO_HALF : BE_HI_HALF;
            DS_WORD: be = BE_WORD;
            default: be = BE_NONE;
        endcase
        return be;
    endfunction

    // Replicate the narrow store value across all lanes; memBe picks the live one.
    function automatic logic [31:0] store_data(input logic [1:0] ds, input logic [31:0] sd);
        logic [31:0] wd;
        case (ds)
            DS_BYTE: wd = {4{sd[7:0]}};
            DS_HALF: wd = {2{sd[15:0]}};
            default: wd = sd;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load-side lane select and extension: picks the big-endian byte/half addressed
// within the returned word and sign- or zero-extends it.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  datasize,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[31:24];
            2'd1:    byte_sel = rdata[23:16];
            2'd2:    byte_sel = rdata[15:8];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    end

    always_comb begin
        case (datasize)
            DS_BYTE: result = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            DS_HALF: result = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            DS_WORD: result = rdata;
            default: result = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store responder: one req/ack transaction per accepted access,
// stalling the pipeline until DONE, with alignment and timeout reporting.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 30,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [1:0]        datasize,
    input  logic              isUnsigned,
    input  logic [31:0]       addr,
    input  logic [31:0]       storeData,
    output logic [31:0]       loadData,
    output logic              stall,
    output logic              misaligned,
    output logic              timeout,
    output logic              memReq,
    output logic              memWe,
    output logic [3:0]        memBe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [31:0]       memWData,
    input  logic [31:0]       memRData,
    input  logic              memAck
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       load_q, load_d;
    logic              timeout_q, timeout_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [1:0]        ds_q, ds_d;
    logic              uns_q, uns_d;

    logic              op;
    logic              bad_align;
    logic              accept;
    logic [31:0]       ext_data;
    logic [7:0]        cnt_inc;

    assign op         = memRead | memWrite;
    assign bad_align  = is_misaligned(datasize, addr[1:0]);
    assign misaligned = op & bad_align;
    assign accept     = (state_q == ST_IDLE) & op & ~bad_align;
    assign stall      = accept | (state_q == ST_ACCESS);
    assign cnt_inc    = cnt_q + 8'd1;

    // Extension uses the size/offset captured at accept, not the live inputs.
    mem_load_align u_align (
        .rdata       (memRData),
        .addr_lo     (addr_lo_q),
        .datasize    (ds_q),
        .is_unsigned (uns_q),
        .result      (ext_data)
    );

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        be_d      = be_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        load_d    = load_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
        addr_lo_d = addr_lo_q;
        ds_d      = ds_q;
        uns_d     = uns_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 8'd0;
                if (accept) begin
                    state_d   = ST_ACCESS;
                    req_d     = 1'b1;
                    we_d      = memWrite;
                    be_d      = store_be(datasize, addr[1:0]);
                    addr_d    = addr[ADDR_W+1:2];
                    wdata_d   = store_data(datasize, storeData);
                    addr_lo_d = addr[1:0];
                    ds_d      = datasize;
                    uns_d     = isUnsigned;
                end
            end
            ST_ACCESS: begin
                if (memAck) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    load_d  = we_q ? 32'h0 : ext_data;
                end else if (cnt_inc == TIMEOUT_CNT) begin
                    state_d   = ST_DONE;
                    req_d     = 1'b0;
                    load_d    = 32'h0;
                    timeout_d = 1'b1;
                    cnt_d     = cnt_inc;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DONE: begin
                // Inputs still show the finished op; it must not be taken again.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= BE_NONE;
            addr_q    <= '0;
            wdata_q   <= 32'h0;
            load_q    <= 32'h0;
            timeout_q <= 1'b0;
            cnt_q     <= 8'd0;
            addr_lo_q <= 2'b00;
            ds_q      <= DS_BYTE;
            uns_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            be_q      <= be_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            load_q    <= load_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            addr_lo_q <= addr_lo_d;
            ds_q      <= ds_d;
            uns_q     <= uns_d;
        end
    end

    assign memReq   = req_q;
    assign memWe    = we_q;
    assign memBe    = be_q;
    assign memAddr  = addr_q;
    assign memWData = wdata_q;
    assign loadData = load_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: expected results are queued when an op is
// driven and popped when the access reaches DONE.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        memRead = 1'b0, memWrite = 1'b0, isUnsigned = 1'b0;
    logic [1:0]  datasize = DS_WORD;
    logic [31:0] addr = 32'h0, storeData = 32'h0;
    logic [31:0] loadData, memWData;
    logic        stall, misaligned, timeout, memReq, memWe;
    logic [3:0]  memBe;
    logic [29:0] memAddr;
    logic [31:0] memRData = 32'hA5A5A5A5;
    logic        memAck = 1'b0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [31:0] ld;
        logic        to;
        int          stall_n;
        int          req_n;
    } exp_t;

    exp_t sb[$];

    mem_access_unit #(.ADDR_W(30), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .memRead(memRead), .memWrite(memWrite),
        .datasize(datasize), .isUnsigned(isUnsigned), .addr(addr), .storeData(storeData),
        .loadData(loadData), .stall(stall), .misaligned(misaligned), .timeout(timeout),
        .memReq(memReq), .memWe(memWe), .memBe(memBe), .memAddr(memAddr),
        .memWData(memWData), .memRData(memRData), .memAck(memAck)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        memRead = 1'b0; memWrite = 1'b0; isUnsigned = 1'b0;
        datasize = DS_WORD; addr = 32'h0; storeData = 32'h0;
    endtask

    task automatic run_op(input string name, input logic wr, input logic rd,
                          input logic [1:0] ds, input logic uns, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rdata, input int ack_delay,
                          input logic [31:0] exp_ld, input logic exp_to, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input int exp_stall, input int exp_req);
        exp_t e;
        exp_t got;
        int   stall_n = 0;
        int   req_n = 0;
        bit   done = 1'b0;
        e.name = name; e.ld = exp_ld; e.to = exp_to; e.stall_n = exp_stall; e.req_n = exp_req;
        sb.push_back(e);
        @(posedge clk); #1;
        memWrite = wr; memRead = rd; datasize = ds; isUnsigned = uns; addr = a; storeData = sd;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 0) chk({name, "_misaligned"}, {31'b0, misaligned}, 32'h0);
            if (stall) stall_n++;
            if (memReq) begin
                req_n++;
                if (req_n == 1) begin
                    chk({name, "_memBe"}, {28'b0, memBe}, {28'b0, exp_be});
                    chk({name, "_memAddr"}, {2'b0, memAddr}, {2'b0, a[31:2]});
                    chk({name, "_memWe"}, {31'b0, memWe}, {31'b0, wr});
                    if (wr) chk({name, "_memWData"}, memWData, exp_wd);
                end
                if (ack_delay >= 0 && req_n == ack_delay + 1) begin
                    memAck = 1'b1; memRData = rdata;
                end else begin
                    memAck = 1'b0; memRData = 32'hA5A5A5A5;
                end
            end else begin
                memAck = 1'b0; memRData = 32'hA5A5A5A5;
                if (!stall && (stall_n > 0 || req_n > 0)) done = 1'b1;
            end
        end
        chk({name, "_reached_done"}, {31'b0, done}, 32'h1);
        got = sb.pop_front();
        chk({got.name, "_loadData"}, loadData, got.ld);
        chk({got.name, "_timeout"}, {31'b0, timeout}, {31'b0, got.to});
        chk({got.name, "_stall_cycles"}, stall_n, got.stall_n);
        chk({got.name, "_req_cycles"}, req_n, got.req_n);
        $display("op %-8s addr=0x%08h loadData=0x%08h timeout=%0b stall=%0d req=%0d",
                 name, a, loadData, timeout, stall_n, req_n);
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        chk({name, "_timeout_pulse_end"}, {31'b0, timeout}, 32'h0);
        chk({name, "_idle_no_req"}, {31'b0, memReq}, 32'h0);
    endtask

    task automatic run_misaligned(input string name, input logic [1:0] ds, input logic [31:0] a);
        int req_seen = 0;
        int stall_seen = 0;
        @(posedge clk); #1;
        memRead = 1'b1; datasize = ds; addr = a;
        @(negedge clk);
        chk({name, "_misaligned"}, {31'b0, misaligned}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            if (memReq) req_seen++;
            if (stall) stall_seen++;
            @(negedge clk);
        end
        chk({name, "_no_req"}, req_seen, 0);
        chk({name, "_no_stall"}, stall_seen, 0);
        $display("op %-8s addr=0x%08h misaligned flagged, req=%0d stall=%0d",
                 name, a, req_seen, stall_seen);
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        chk({name, "_misaligned_clear"}, {31'b0, misaligned}, 32'h0);
    endtask

    initial begin
        int late_req = 0;
        #2;
        chk("reset_memReq", {31'b0, memReq}, 32'h0);
        chk("reset_memWe", {31'b0, memWe}, 32'h0);
        chk("reset_memBe", {28'b0, memBe}, 32'h0);
        chk("reset_memAddr", {2'b0, memAddr}, 32'h0);
        chk("reset_memWData", memWData, 32'h0);
        chk("reset_loadData", loadData, 32'h0);
        chk("reset_timeout", {31'b0, timeout}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        //      name     wr    rd    ds       uns   addr          sd            rdata         ack ld            to    be       wdata        st rq
        run_op("SW",     1'b1, 1'b0, DS_WORD, 1'b0, 32'h00000100, 32'hDEADBEEF, 32'h0,        0, 32'h0,        1'b0, 4'b1111, 32'hDEADBEEF, 2, 1);
        chk("SW_memAddr_0x40", {2'b0, memAddr}, 32'h40);
        run_op("LB",     1'b0, 1'b1, DS_BYTE, 1'b0, 32'h00000103, 32'h0, 32'h112233F0, 0, 32'hFFFFFFF0, 1'b0, 4'b0001, 32'h0,        2, 1);
        run_op("LBU",    1'b0, 1'b1, DS_BYTE, 1'b1, 32'h00000103, 32'h0, 32'h112233F0, 1, 32'h000000F0, 1'b0, 4'b0001, 32'h0,        3, 2);
        run_op("SH",     1'b1, 1'b0, DS_HALF, 1'b0, 32'h00000102, 32'h0000ABCD, 32'h0,  0, 32'h0,        1'b0, 4'b0011, 32'hABCDABCD, 2, 1);
        run_op("LH",     1'b0, 1'b1, DS_HALF, 1'b0, 32'h00000100, 32'h0, 32'h8001A5A5, 0, 32'hFFFF8001, 1'b0, 4'b1100, 32'h0,        2, 1);
        run_op("LHU",    1'b0, 1'b1, DS_HALF, 1'b1, 32'h00000102, 32'h0, 32'h1234F00D, 0, 32'h0000F00D, 1'b0, 4'b0011, 32'h0,        2, 1);
        run_op("SB_RW",  1'b1, 1'b1, DS_BYTE, 1'b0, 32'h00000101, 32'h12345678, 32'h0,  0, 32'h0,        1'b0, 4'b0100, 32'h78787878, 2, 1);
        run_op("LW",     1'b0, 1'b1, DS_WORD, 1'b0, 32'h00000104, 32'h0, 32'hCAFEBABE, 2, 32'hCAFEBABE, 1'b0, 4'b1111, 32'h0,        4, 3);
        run_op("LW_TO",  1'b0, 1'b1, DS_WORD, 1'b0, 32'h00000200, 32'h0, 32'h0,       -1, 32'h0,        1'b1, 4'b1111, 32'h0,        5, 4);
        run_op("LB_POS", 1'b0, 1'b1, DS_BYTE, 1'b0, 32'h00000100, 32'h0, 32'h7F00FF00, 0, 32'h0000007F, 1'b0, 4'b1000, 32'h0,        2, 1);

        run_misaligned("LW_ODD", DS_WORD, 32'h00000101);
        run_misaligned("LH_ODD", DS_HALF, 32'h00000103);
        run_misaligned("DS_10",  2'b10,   32'h00000100);

        // Reset asserted while the request is outstanding; a late ack must be ignored.
        @(posedge clk); #1;
        memRead = 1'b1; datasize = DS_WORD; addr = 32'h00000300;
        @(negedge clk);
        @(negedge clk);
        chk("RST_req_before", {31'b0, memReq}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("RST_req_dropped", {31'b0, memReq}, 32'h0);
        chk("RST_loadData", loadData, 32'h0);
        clear_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        memAck = 1'b1; memRData = 32'h55667788;
        @(negedge clk);
        memAck = 1'b0; memRData = 32'hA5A5A5A5;
        for (int i = 0; i < 4; i++) begin
            if (memReq || stall) late_req++;
            @(negedge clk);
        end
        chk("RST_late_ack_ignored", late_req, 0);
        chk("RST_loadData_after", loadData, 32'h0);
        chk("RST_timeout_after", {31'b0, timeout}, 32'h0);
        $display("op RESET   late ack ignored, loadData=0x%08h", loadData);

        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
